// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the pipelined MIPS core.
// - datapath widths (BITS, OPTION_BITS, REG_BITS)
// - alu select codes (shared opcode/function encoding)
// - id_ex_t: the bundle held in the ID/EX pipeline register
package cpu_pkg;

  localparam int BITS        = 32;
  localparam int OPTION_BITS = 8;
  localparam int REG_BITS    = 5;

  localparam logic [OPTION_BITS-1:0] ALU_ADD  = 8'h20;
  localparam logic [OPTION_BITS-1:0] ALU_ADDI = 8'h08;
  localparam logic [OPTION_BITS-1:0] ALU_AND  = 8'h24;
  localparam logic [OPTION_BITS-1:0] ALU_OR   = 8'h25;
  localparam logic [OPTION_BITS-1:0] ALU_ORI  = 8'h0D;
  localparam logic [OPTION_BITS-1:0] ALU_LW   = 8'h23;
  localparam logic [OPTION_BITS-1:0] ALU_SUB  = 8'h22;
  localparam logic [OPTION_BITS-1:0] ALU_SW   = 8'h2B;
  localparam logic [OPTION_BITS-1:0] ALU_MUL  = 8'h3A;

  typedef struct packed {
    logic                   valid;
    logic [OPTION_BITS-1:0] select;
    logic [BITS-1:0]        rs_val;
    logic [BITS-1:0]        rt_val;
    logic [BITS-1:0]        imm;
    logic                   use_imm;
    logic [REG_BITS-1:0]    rs;
    logic [REG_BITS-1:0]    rt;
    logic [REG_BITS-1:0]    rd;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: every non-clock signal of the ID/EX stage.
// - id_*          decoded instruction from the decode stage
// - flush, hold   pipeline control
// - exm_*, mwb_*  writeback ports of EX/MEM and MEM/WB used for forwarding
// - load_use_stall, ex_*, alu_*  results of the stage
// Modport master: the surrounding pipeline; slave: the ID/EX stage.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic                   id_valid;
  logic [OPTION_BITS-1:0] id_select;
  logic [BITS-1:0]        id_rs_val;
  logic [BITS-1:0]        id_rt_val;
  logic [BITS-1:0]        id_imm;
  logic                   id_use_imm;
  logic                   id_uses_rt;
  logic [REG_BITS-1:0]    id_rs;
  logic [REG_BITS-1:0]    id_rt;
  logic [REG_BITS-1:0]    id_rd;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic                   id_mem_write;
  logic                   flush;
  logic                   hold;
  logic                   exm_reg_write;
  logic [REG_BITS-1:0]    exm_rd;
  logic [BITS-1:0]        exm_result;
  logic                   mwb_reg_write;
  logic [REG_BITS-1:0]    mwb_rd;
  logic [BITS-1:0]        mwb_result;
  logic                   load_use_stall;
  logic                   ex_valid;
  logic [OPTION_BITS-1:0] alu_select;
  logic [BITS-1:0]        alu_a;
  logic [BITS-1:0]        alu_b;
  logic [BITS-1:0]        ex_store_data;
  logic [REG_BITS-1:0]    ex_rd;
  logic                   ex_reg_write;
  logic                   ex_mem_read;
  logic                   ex_mem_write;

  modport master (
    output id_valid, id_select, id_rs_val, id_rt_val, id_imm, id_use_imm, id_uses_rt,
           id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_mem_write,
           flush, hold, exm_reg_write, exm_rd, exm_result,
           mwb_reg_write, mwb_rd, mwb_result,
    input  load_use_stall, ex_valid, alu_select, alu_a, alu_b, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_select, id_rs_val, id_rt_val, id_imm, id_use_imm, id_uses_rt,
           id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_mem_write,
           flush, hold, exm_reg_write, exm_rd, exm_result,
           mwb_reg_write, mwb_rd, mwb_result,
    output load_use_stall, ex_valid, alu_select, alu_a, alu_b, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: selects the freshest value of one source register.
// Ports: src (source index), reg_val (value read in decode),
//        exm_* / mwb_* (writeback ports), fwd (forwarded value).
// EX/MEM is younger than MEM/WB, so it wins; register 0 is never forwarded.
module fwd_mux #(
  parameter int BITS     = 32,
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] src,
  input  logic [BITS-1:0]     reg_val,
  input  logic                exm_reg_write,
  input  logic [REG_BITS-1:0] exm_rd,
  input  logic [BITS-1:0]     exm_result,
  input  logic                mwb_reg_write,
  input  logic [REG_BITS-1:0] mwb_rd,
  input  logic [BITS-1:0]     mwb_result,
  output logic [BITS-1:0]     fwd
);

  // Priority select between the two writeback ports and the register-file value
  always_comb begin
    fwd = reg_val;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == src)) begin
      fwd = exm_result;
    end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src)) begin
      fwd = mwb_result;
    end else begin
      fwd = reg_val;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the pipelined MIPS core.
// Ports: clk, rst (synchronous, active-high), bus (id_ex_stage_if.slave)
//   carrying the decoded instruction, flush/hold, both writeback ports and
//   the alu operands / EX controls driven out.
// The register captures one decoded instruction per cycle; forwarding and
// the immediate mux sit combinationally after it. A load followed by a
// dependent instruction produces load_use_stall and a bubble in EX.
module id_ex_stage
  import cpu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  id_ex_t          ex_r;
  id_ex_t          ex_next;
  logic            stall;
  logic [BITS-1:0] fwd_rs;
  logic [BITS-1:0] fwd_rt;
  id_ex_t          captured;

  // Load result is not available until MEM, so a dependent instruction must wait one cycle
  always_comb begin
    stall = ex_r.valid && ex_r.mem_read && (ex_r.rd != '0) && bus.id_valid &&
            ((ex_r.rd == bus.id_rs) || (bus.id_uses_rt && (ex_r.rd == bus.id_rt)));
  end

  // Bundle the decode-side fields
  always_comb begin
    captured.valid     = bus.id_valid;
    captured.select    = bus.id_select;
    captured.rs_val    = bus.id_rs_val;
    captured.rt_val    = bus.id_rt_val;
    captured.imm       = bus.id_imm;
    captured.use_imm   = bus.id_use_imm;
    captured.rs        = bus.id_rs;
    captured.rt        = bus.id_rt;
    captured.rd        = bus.id_rd;
    captured.reg_write = bus.id_reg_write;
    captured.mem_read  = bus.id_mem_read;
    captured.mem_write = bus.id_mem_write;
  end

  // Next-state priority: flush, hold, load-use bubble, capture (an all-zero bundle is a bubble)
  always_comb begin
    ex_next = '0;
    if (bus.flush) begin
      ex_next = '0;
    end else if (bus.hold) begin
      ex_next = ex_r;
    end else if (stall) begin
      ex_next = '0;
    end else begin
      ex_next = captured;
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else begin
      ex_r <= ex_next;
    end
  end

  fwd_mux #(.BITS(BITS), .REG_BITS(REG_BITS)) u_fwd_rs (
    .src(ex_r.rs), .reg_val(ex_r.rs_val),
    .exm_reg_write(bus.exm_reg_write), .exm_rd(bus.exm_rd), .exm_result(bus.exm_result),
    .mwb_reg_write(bus.mwb_reg_write), .mwb_rd(bus.mwb_rd), .mwb_result(bus.mwb_result),
    .fwd(fwd_rs)
  );

  fwd_mux #(.BITS(BITS), .REG_BITS(REG_BITS)) u_fwd_rt (
    .src(ex_r.rt), .reg_val(ex_r.rt_val),
    .exm_reg_write(bus.exm_reg_write), .exm_rd(bus.exm_rd), .exm_result(bus.exm_result),
    .mwb_reg_write(bus.mwb_reg_write), .mwb_rd(bus.mwb_rd), .mwb_result(bus.mwb_result),
    .fwd(fwd_rt)
  );

  // A bubble carries select 0, so the alu just passes a and nothing downstream commits
  assign bus.load_use_stall = stall;
  assign bus.ex_valid       = ex_r.valid;
  assign bus.alu_select     = ex_r.select;
  assign bus.alu_a          = fwd_rs;
  assign bus.alu_b          = ex_r.use_imm ? ex_r.imm : fwd_rt;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.ex_rd          = ex_r.rd;
  assign bus.ex_reg_write   = ex_r.reg_write;
  assign bus.ex_mem_read    = ex_r.mem_read;
  assign bus.ex_mem_write   = ex_r.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage with hand-computed
// expected values. Inputs change 1 ns after the rising edge; outputs are
// sampled before the next rising edge.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  id_ex_stage_if bus ();

  id_ex_stage u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic valid, input logic [7:0] sel,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rs_val, input logic [31:0] rt_val,
                        input logic [31:0] imm, input logic use_imm, input logic uses_rt,
                        input logic reg_write, input logic mem_read, input logic mem_write);
    bus.id_valid     = valid;
    bus.id_select    = sel;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_val    = rs_val;
    bus.id_rt_val    = rt_val;
    bus.id_imm       = imm;
    bus.id_use_imm   = use_imm;
    bus.id_uses_rt   = uses_rt;
    bus.id_reg_write = reg_write;
    bus.id_mem_read  = mem_read;
    bus.id_mem_write = mem_write;
  endtask

  task automatic set_wb(input logic exm_we, input logic [4:0] exm_rd, input logic [31:0] exm_res,
                        input logic mwb_we, input logic [4:0] mwb_rd, input logic [31:0] mwb_res);
    bus.exm_reg_write = exm_we;
    bus.exm_rd        = exm_rd;
    bus.exm_result    = exm_res;
    bus.mwb_reg_write = mwb_we;
    bus.mwb_rd        = mwb_rd;
    bus.mwb_result    = mwb_res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles with a valid instruction in decode
    tick();
    tick();
    check_val("rst_valid",  32'(bus.ex_valid), 32'h0);
    check_val("rst_select", 32'(bus.alu_select), 32'h0);
    check_val("rst_alu_a",  bus.alu_a, 32'h0);
    check_val("rst_alu_b",  bus.alu_b, 32'h0);
    rst = 1'b0;

    // ADD r3 = r1 + r2
    set_id(1'b1, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_val("add_valid",  32'(bus.ex_valid), 32'h1);
    check_val("add_select", 32'(bus.alu_select), 32'h20);
    check_val("add_alu_a",  bus.alu_a, 32'd5);
    check_val("add_alu_b",  bus.alu_b, 32'd7);
    check_val("add_rd",     32'(bus.ex_rd), 32'd3);
    check_val("add_we",     32'(bus.ex_reg_write), 32'h1);

    // Double forward rs=rt=4
    set_id(1'b1, ALU_ADD, 5'd4, 5'd4, 5'd5, 32'h44, 32'h44, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
    tick();
    check_val("fwd_exm_a",  bus.alu_a, 32'h11);
    check_val("fwd_exm_b",  bus.alu_b, 32'h11);
    check_val("fwd_exm_sd", bus.ex_store_data, 32'h11);
    bus.exm_reg_write = 1'b0;
    #1;
    check_val("fwd_mwb_a", bus.alu_a, 32'h22);
    check_val("fwd_mwb_b", bus.alu_b, 32'h22);
    set_wb(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
    #1;
    check_val("fwd_none_a", bus.alu_a, 32'h44);
    check_val("fwd_none_b", bus.alu_b, 32'h44);

    // Register 0 is never forwarded
    set_id(1'b1, ALU_ADD, 5'd0, 5'd0, 5'd7, 32'h99, 32'h98, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    tick();
    check_val("r0_alu_a", bus.alu_a, 32'h99);
    check_val("r0_alu_b", bus.alu_b, 32'h98);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Load-use: LW r8, then ADD using r8
    set_id(1'b1, ALU_LW, 5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_val("lw_mem_read", 32'(bus.ex_mem_read), 32'h1);
    check_val("lw_alu_b",    bus.alu_b, 32'd4);
    set_id(1'b1, ALU_ADD, 5'd8, 5'd2, 5'd9, 32'hDEAD, 32'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_val("lu_stall", 32'(bus.load_use_stall), 32'h1);
    tick();
    check_val("lu_bubble_valid",  32'(bus.ex_valid), 32'h0);
    check_val("lu_bubble_select", 32'(bus.alu_select), 32'h0);
    check_val("lu_bubble_we",     32'(bus.ex_reg_write), 32'h0);
    check_val("lu_stall_gone",    32'(bus.load_use_stall), 32'h0);
    set_wb(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h55);
    tick();
    check_val("lu_add_valid",  32'(bus.ex_valid), 32'h1);
    check_val("lu_add_select", 32'(bus.alu_select), 32'h20);
    check_val("lu_add_alu_a",  bus.alu_a, 32'h55);
    check_val("lu_add_alu_b",  bus.alu_b, 32'd3);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // ADDI whose rt matches the load destination: no stall, b is the immediate
    set_id(1'b1, ALU_LW, 5'd1, 5'd6, 5'd6, 32'h100, 32'h0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, ALU_ADDI, 5'd1, 5'd6, 5'd6, 32'd10, 32'h0, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 32'h0);
    #1;
    check_val("addi_no_stall", 32'(bus.load_use_stall), 32'h0);
    tick();
    check_val("addi_select", 32'(bus.alu_select), 32'h08);
    check_val("addi_alu_a",  bus.alu_a, 32'd10);
    check_val("addi_alu_b",  bus.alu_b, 32'hFFFFFFFC);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Flush together with a load-use hazard
    set_id(1'b1, ALU_LW, 5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, ALU_ADD, 5'd2, 5'd8, 5'd9, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    check_val("flush_stall", 32'(bus.load_use_stall), 32'h1);
    tick();
    bus.flush = 1'b0;
    check_val("flush_valid", 32'(bus.ex_valid), 32'h0);
    check_val("flush_rd",    32'(bus.ex_rd), 32'h0);
    check_val("flush_rmw",   32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}), 32'h0);

    // Hold for three cycles while decode changes
    set_id(1'b1, ALU_SUB, 5'd1, 5'd2, 5'd4, 32'd20, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_val("sub_select", 32'(bus.alu_select), 32'h22);
    set_id(1'b1, ALU_OR, 5'd3, 5'd5, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("hold_select", 32'(bus.alu_select), 32'h22);
      check_val("hold_alu_a",  bus.alu_a, 32'd20);
      check_val("hold_alu_b",  bus.alu_b, 32'd6);
      check_val("hold_rd",     32'(bus.ex_rd), 32'd4);
      check_val("hold_mw",     32'(bus.ex_mem_write), 32'h1);
    end

    // Flush and hold together: flush wins
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    check_val("fh_valid",  32'(bus.ex_valid), 32'h0);
    check_val("fh_select", 32'(bus.alu_select), 32'h0);
    check_val("fh_rd",     32'(bus.ex_rd), 32'h0);

    // Reset in mid-operation
    tick();
    check_val("pre_rst_valid", 32'(bus.ex_valid), 32'h1);
    check_val("pre_rst_a",     bus.alu_a, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_valid", 32'(bus.ex_valid), 32'h0);
    check_val("mid_rst_a",     bus.alu_a, 32'h0);
    check_val("mid_rst_b",     bus.alu_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
